// File: rtl/s6_avmm_pkg.sv
// ----------------------------------------------------------------------------
// s6_avmm_pkg: address map, region decode and byte-merge helper for the responder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package s6_avmm_pkg;

  localparam logic [19:0] ADDR_ID       = 20'h00000;
  localparam logic [19:0] ADDR_SCRATCH  = 20'h00004;
  localparam logic [19:0] ADDR_WR_CNT   = 20'h00008;
  localparam logic [19:0] ADDR_RD_CNT   = 20'h0000C;
  localparam logic [19:0] ADDR_ERR_CNT  = 20'h00010;
  localparam logic [19:0] RAM_BASE      = 20'h01000;
  localparam int          RAM_WORDS     = 256;
  localparam int          RAM_AW        = 8;
  localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    REGION_ID,
    REGION_SCRATCH,
    REGION_WR_CNT,
    REGION_RD_CNT,
    REGION_ERR_CNT,
    REGION_RAM,
    REGION_UNMAPPED
  } region_e;

  // The RAM window is the 1 KiB block at RAM_BASE, so only bits [19:10] pick it.
  function automatic region_e decode_region(input logic [19:0] addr);
    logic [19:0] word_addr;
    word_addr = {addr[19:2], 2'b00};
    if (word_addr[19:10] == RAM_BASE[19:10]) begin
      return REGION_RAM;
    end
    case (word_addr)
      ADDR_ID:      return REGION_ID;
      ADDR_SCRATCH: return REGION_SCRATCH;
      ADDR_WR_CNT:  return REGION_WR_CNT;
      ADDR_RD_CNT:  return REGION_RD_CNT;
      ADDR_ERR_CNT: return REGION_ERR_CNT;
      default:      return REGION_UNMAPPED;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/s6_resp_ram.sv
// ----------------------------------------------------------------------------
// s6_resp_ram: 256x32 single-port RAM, byte-enabled writes, registered write-first read
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module s6_resp_ram
  import s6_avmm_pkg::*;
(
  input  logic              clk,
  input  logic              re,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        be,
  output logic [31:0]       rdata
);

  logic [31:0] mem [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Output only moves on a read so the responder can hold readdata between beats.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= we ? merge_bytes(mem[addr], wdata, be) : mem[addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/s6_avmm_responder.sv
// ----------------------------------------------------------------------------
// s6_avmm_responder: AVMM responder with ID/scratch/counter registers and a 256-word RAM
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module s6_avmm_responder
  import s6_avmm_pkg::*;
#(
  parameter int          ADDR_W       = 20,
  parameter int          DATA_W       = 32,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] BLOCK_ID     = 32'h5336_0001
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic [ADDR_W-1:0]   avmm_slave_address,
  input  logic                avmm_slave_read,
  input  logic                avmm_slave_write,
  input  logic [DATA_W-1:0]   avmm_slave_writedata,
  input  logic [DATA_W/8-1:0] avmm_slave_byteenable,
  output logic                avmm_slave_waitrequest,
  output logic [DATA_W-1:0]   avmm_slave_readdata,
  output logic                avmm_slave_readdatavalid
);

  logic        in_reset;
  logic        accept;
  logic        acc_wr;
  logic        acc_rd;
  logic        err_event;
  region_e     region;

  logic [31:0] scratch;
  logic [31:0] wr_cnt;
  logic [31:0] rd_cnt;
  logic [31:0] err_cnt;

  logic [31:0] reg_rdata;
  logic        s1_valid;
  logic        s1_is_ram;
  logic [31:0] s1_data;
  logic [31:0] stage1_data;
  logic [31:0] ram_rdata;
  logic        ram_re;
  logic        ram_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_reset <= 1'b1;
    end else begin
      in_reset <= 1'b0;
    end
  end

  assign avmm_slave_waitrequest = freeze | in_reset;

  assign region = decode_region(avmm_slave_address);
  assign accept = (avmm_slave_read | avmm_slave_write) & ~avmm_slave_waitrequest;
  assign acc_wr = accept & avmm_slave_write;
  // A read that arrives together with a write is discarded, so it is not a read.
  assign acc_rd = accept & avmm_slave_read & ~avmm_slave_write;

  always_comb begin
    err_event = 1'b0;
    if (accept) begin
      if (avmm_slave_write && avmm_slave_read) begin
        err_event = 1'b1;
      end
      if (region == REGION_UNMAPPED) begin
        err_event = 1'b1;
      end
      if (avmm_slave_write && region == REGION_ID) begin
        err_event = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scratch <= '0;
    end else if (acc_wr && region == REGION_SCRATCH) begin
      scratch <= merge_bytes(scratch, avmm_slave_writedata, avmm_slave_byteenable);
    end
  end

  // A write to WR_CNT counts and clears in one step, leaving it at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt <= '0;
    end else if (acc_wr) begin
      wr_cnt <= (region == REGION_WR_CNT) ? 32'd0 : wr_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt <= '0;
    end else if (acc_wr && region == REGION_RD_CNT) begin
      rd_cnt <= '0;
    end else if (acc_rd) begin
      rd_cnt <= rd_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (acc_wr && region == REGION_ERR_CNT) begin
      err_cnt <= '0;
    end else if (err_event) begin
      err_cnt <= err_cnt + 32'd1;
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (region)
      REGION_ID:      reg_rdata = BLOCK_ID;
      REGION_SCRATCH: reg_rdata = scratch;
      REGION_WR_CNT:  reg_rdata = wr_cnt;
      REGION_RD_CNT:  reg_rdata = rd_cnt;
      REGION_ERR_CNT: reg_rdata = err_cnt;
      REGION_RAM:     reg_rdata = '0;
      default:        reg_rdata = UNMAPPED_DATA;
    endcase
  end

  assign ram_re = acc_rd & (region == REGION_RAM);
  assign ram_we = acc_wr & (region == REGION_RAM);

  s6_resp_ram u_ram (
    .clk   (clk),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (avmm_slave_address[RAM_AW+1:2]),
    .wdata (avmm_slave_writedata),
    .be    (avmm_slave_byteenable),
    .rdata (ram_rdata)
  );

  // Stage 1 lines up with the RAM's registered output; register reads ride beside it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_is_ram <= 1'b0;
      s1_data   <= '0;
    end else begin
      s1_valid <= acc_rd;
      if (acc_rd) begin
        s1_is_ram <= (region == REGION_RAM);
        s1_data   <= reg_rdata;
      end
    end
  end

  assign stage1_data = s1_is_ram ? ram_rdata : s1_data;

  generate
    if (READ_LATENCY <= 1) begin : g_lat1
      assign avmm_slave_readdatavalid = s1_valid;
      assign avmm_slave_readdata      = stage1_data;
    end else begin : g_pipe
      logic [READ_LATENCY:2] pipe_valid;
      logic [31:0]           pipe_data [2:READ_LATENCY];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pipe_valid <= '0;
          for (int k = 2; k <= READ_LATENCY; k++) begin
            pipe_data[k] <= '0;
          end
        end else begin
          pipe_valid[2] <= s1_valid;
          if (s1_valid) begin
            pipe_data[2] <= stage1_data;
          end
          for (int k = 3; k <= READ_LATENCY; k++) begin
            pipe_valid[k] <= pipe_valid[k-1];
            if (pipe_valid[k-1]) begin
              pipe_data[k] <= pipe_data[k-1];
            end
          end
        end
      end

      assign avmm_slave_readdatavalid = pipe_valid[READ_LATENCY];
      assign avmm_slave_readdata      = pipe_data[READ_LATENCY];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_s6_avmm_responder.sv
// ----------------------------------------------------------------------------
// tb_s6_avmm_responder: directed + random bench for s6_avmm_responder against a behavioural model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_s6_avmm_responder;

  localparam int          LAT = 2;
  localparam logic [31:0] ID  = 32'h5336_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        rd;
  logic        wr;
  logic [19:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        waitreq;
  logic [31:0] rdata;
  logic        rvalid;

  always #5 clk = ~clk;

  s6_avmm_responder #(
    .ADDR_W       (20),
    .DATA_W       (32),
    .READ_LATENCY (LAT),
    .BLOCK_ID     (ID)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .freeze                   (freeze),
    .avmm_slave_address       (addr),
    .avmm_slave_read          (rd),
    .avmm_slave_write         (wr),
    .avmm_slave_writedata     (wdata),
    .avmm_slave_byteenable    (be),
    .avmm_slave_waitrequest   (waitreq),
    .avmm_slave_readdata      (rdata),
    .avmm_slave_readdatavalid (rvalid)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Behavioural model state
  logic [31:0] m_ram [256];
  logic [31:0] m_scratch, m_wr, m_rd, m_err, m_last;
  logic        m_in_reset;
  int          due_q[$];
  logic [31:0] data_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic bit is_ram(input logic [19:0] a);
    logic [19:0] w;
    w = {a[19:2], 2'b00};
    return (w >= 20'h01000) && (w <= 20'h013FC);
  endfunction

  function automatic bit is_unmapped(input logic [19:0] a);
    logic [19:0] w;
    w = {a[19:2], 2'b00};
    return !is_ram(a) && (w > 20'h00010);
  endfunction

  function automatic logic [31:0] m_read(input logic [19:0] a);
    logic [19:0] w;
    w = {a[19:2], 2'b00};
    if (is_ram(a)) return m_ram[w[9:2]];
    case (w)
      20'h00000: return ID;
      20'h00004: return m_scratch;
      20'h00008: return m_wr;
      20'h0000C: return m_rd;
      20'h00010: return m_err;
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic model_reset();
    m_scratch  = '0;
    m_wr       = '0;
    m_rd       = '0;
    m_err      = '0;
    m_last     = '0;
    m_in_reset = 1'b1;
    due_q.delete();
    data_q.delete();
  endtask

  task automatic model_cmd();
    logic [19:0] w;
    bit          err;
    w = {addr[19:2], 2'b00};
    if (wr) begin
      m_wr = m_wr + 1;
      err  = rd || is_unmapped(addr) || (w == 20'h00000);
      if (err) m_err = m_err + 1;
      if (is_ram(addr))          m_ram[w[9:2]] = merge(m_ram[w[9:2]], wdata, be);
      else if (w == 20'h00004)   m_scratch = merge(m_scratch, wdata, be);
      else if (w == 20'h00008)   m_wr = '0;
      else if (w == 20'h0000C)   m_rd = '0;
      else if (w == 20'h00010)   m_err = '0;
    end else begin
      due_q.push_back(edge_n + LAT - 1);
      data_q.push_back(m_read(addr));
      if (is_unmapped(addr)) m_err = m_err + 1;
      m_rd = m_rd + 1;
    end
  endtask

  // One clock: check waitrequest before the edge, update the model at the edge,
  // then check the read return path just after it.
  task automatic tick();
    logic exp_wait;
    #1;
    exp_wait = freeze | m_in_reset;
    check("waitrequest", {31'd0, waitreq}, {31'd0, exp_wait});
    @(posedge clk);
    edge_n++;
    if (rst) begin
      if ((rd || wr) && !exp_wait) model_cmd();
      m_in_reset = 1'b0;
    end
    #1;
    if (due_q.size() > 0 && due_q[0] == edge_n) begin
      check("readdatavalid", {31'd0, rvalid}, 32'd1);
      check("readdata", rdata, data_q[0]);
      m_last = data_q[0];
      void'(due_q.pop_front());
      void'(data_q.pop_front());
    end else begin
      check("readdatavalid_idle", {31'd0, rvalid}, 32'd0);
      check("readdata_hold", rdata, m_last);
    end
    @(negedge clk);
  endtask

  task automatic cmd(input logic r, input logic w, input logic [19:0] a,
                     input logic [31:0] d, input logic [3:0] m);
    rd = r; wr = w; addr = a; wdata = d; be = m;
    tick();
  endtask

  task automatic idle(input int n);
    rd = 1'b0; wr = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic assert_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_waitrequest", {31'd0, waitreq}, 32'd1);
    check("rst_readdatavalid", {31'd0, rvalid}, 32'd0);
    check("rst_readdata", rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] a;
    int          sel;
    freeze = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; be = '0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    assert_reset();
    idle(2);

    // Release reset with a read already pending: first edge must not accept it.
    rst = 1'b1;
    cmd(1'b1, 1'b0, 20'h00000, '0, 4'h0);
    cmd(1'b1, 1'b0, 20'h00000, '0, 4'h0);
    idle(2);
    check("id_read", rdata, 32'h5336_0001);

    for (int i = 0; i < 256; i++) cmd(1'b0, 1'b1, 20'h01000 + 20'(4 * i), $urandom, 4'hF);

    cmd(1'b0, 1'b1, 20'h01010, 32'h0, 4'hF);
    cmd(1'b0, 1'b1, 20'h01010, 32'hAABB_CCDD, 4'b0101);
    cmd(1'b1, 1'b0, 20'h01010, '0, 4'h0);
    idle(3);
    check("byteenable_read", rdata, 32'h00BB_00DD);

    // Back-to-back reads after clearing RD_CNT
    cmd(1'b0, 1'b1, 20'h0000C, 32'h0, 4'hF);
    for (int i = 0; i < 8; i++) cmd(1'b1, 1'b0, 20'h01000 + 20'(4 * $urandom_range(0, 255)), '0, 4'h0);
    cmd(1'b1, 1'b0, 20'h0000C, '0, 4'h0);
    idle(3);
    check("rd_cnt_after_8", rdata, 32'd8);

    cmd(1'b1, 1'b0, 20'h40000, '0, 4'h0);
    idle(2);
    check("unmapped_read", rdata, 32'hDEAD_BEEF);
    cmd(1'b1, 1'b0, 20'h00010, '0, 4'h0);
    idle(2);
    check("err_cnt_1", rdata, 32'd1);

    cmd(1'b1, 1'b1, 20'h00004, 32'h1234_5678, 4'hF);
    idle(3);
    cmd(1'b1, 1'b0, 20'h00004, '0, 4'h0);
    idle(2);
    check("rw_write_applied", rdata, 32'h1234_5678);
    cmd(1'b1, 1'b0, 20'h00010, '0, 4'h0);
    idle(2);
    check("err_cnt_2", rdata, 32'd2);
    cmd(1'b0, 1'b1, 20'h0000C, 32'h0, 4'hF);

    // Freeze with two reads in flight
    cmd(1'b1, 1'b0, 20'h01020, '0, 4'h0);
    cmd(1'b1, 1'b0, 20'h01024, '0, 4'h0);
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd(1'b1, 1'b0, 20'h01028, '0, 4'h0);
      check("freeze_waitrequest", {31'd0, waitreq}, 32'd1);
    end
    freeze = 1'b0;
    cmd(1'b1, 1'b0, 20'h01028, '0, 4'h0);
    idle(3);

    // WR_CNT wrap
    force dut.wr_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.wr_cnt;
    m_wr = 32'hFFFF_FFFF;
    cmd(1'b0, 1'b1, 20'h00004, 32'hCAFE_0000, 4'hF);
    cmd(1'b1, 1'b0, 20'h00008, '0, 4'h0);
    idle(2);
    check("wr_cnt_wrap", rdata, 32'd0);

    for (int i = 0; i < 400; i++) begin
      freeze = ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 7);
      if (sel < 4)       a = 20'h01000 + 20'(4 * $urandom_range(0, 255));
      else if (sel < 6)  a = 20'(4 * $urandom_range(0, 4));
      else begin
        case ($urandom_range(0, 3))
          0:       a = 20'h40000;
          1:       a = 20'h00020;
          2:       a = 20'h01400;
          default: a = 20'hFFFFC;
        endcase
      end
      a[1:0] = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       cmd(1'b1, 1'b0, a, '0, 4'h0);
        1:       cmd(1'b0, 1'b1, a, $urandom, 4'($urandom_range(0, 15)));
        default: idle(1);
      endcase
    end
    freeze = 1'b0;
    idle(4);
    cmd(1'b1, 1'b0, 20'h00010, '0, 4'h0);
    cmd(1'b1, 1'b0, 20'h00008, '0, 4'h0);
    cmd(1'b1, 1'b0, 20'h0000C, '0, 4'h0);
    idle(3);

    // Reset with reads in flight: nothing may come back afterwards
    cmd(1'b1, 1'b0, 20'h00000, '0, 4'h0);
    cmd(1'b1, 1'b0, 20'h00004, '0, 4'h0);
    rd = 1'b0;
    assert_reset();
    idle(3);
    rst = 1'b1;
    idle(4);
    cmd(1'b1, 1'b0, 20'h00004, '0, 4'h0);
    idle(2);
    check("scratch_after_reset", rdata, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/s6_avmm_responder.md
# s6_avmm_responder

Avalon-MM responder (slave) for sector-6 PR user logic on the test NoC. It terminates the user master's 20-bit address / 32-bit data AVMM transactions and provides ID, scratch and counter registers plus a 256-word byte-enabled RAM. Reads are pipelined with fixed latency, and a freeze input stalls new commands during partial reconfiguration. It is the target the PR master exercises for NoC loopback and traffic testing.

## Interface
- ADDR_W, 20, byte address width
- DATA_W, 32, data width; fixed at 32
- READ_LATENCY, 2, accept-to-readdatavalid cycles; legal range 1..4
- BLOCK_ID, 32'h5336_0001, value returned by the ID register

- clk  in  1  sole clock
- rst  in  1  reset; asynchronous assert, active-low (0 = reset), released synchronously to clk by the system
- freeze  in  1  PR freeze; 1 blocks new commands
- avmm_slave_address  in  20  byte address; bits [1:0] are ignored
- avmm_slave_read  in  1  read request
- avmm_slave_write  in  1  write request
- avmm_slave_writedata  in  32  write data
- avmm_slave_byteenable  in  4  write byte lanes
- avmm_slave_waitrequest  out  1  1 = command not accepted this cycle
- avmm_slave_readdata  out  32  read data
- avmm_slave_readdatavalid  out  1  read data qualifier

## Operation
- Accept: a command is accepted at a rising edge where (read|write)=1 and waitrequest=0.
- Waitrequest: waitrequest = freeze | in_reset, where in_reset is a registered flag.
  - in_reset is 1 during reset and clears on the first clk edge after rst goes high.
  - Waitrequest is combinational from freeze only; there is no other stall source.
- Address map (word-aligned byte addresses):
  - 0x00000 ID: RO, returns BLOCK_ID.
  - 0x00004 SCRATCH: RW, honours byteenable, reset 0.
  - 0x00008 WR_CNT: accepted writes; any write to this address clears it.
  - 0x0000C RD_CNT: accepted reads; any write to this address clears it.
  - 0x00010 ERR_CNT: unmapped or illegal accesses; any write to this address clears it.
  - 0x01000–0x013FC RAM: 256 words, indexed by address[9:2]; byteenable applies; not reset.
  - All other addresses are unmapped: reads return 32'hDEAD_BEEF, writes are dropped, ERR_CNT increments.
- Read and write asserted together: the write executes, the read is discarded (no readdatavalid), and ERR_CNT increments.
- Counters: all three are 32 bits and wrap from 0xFFFF_FFFF to 0.
  - A write to a counter address counts in WR_CNT first, then clears the addressed counter. Clearing WR_CNT itself leaves it at 0.
- Writes to ID: dropped, and ERR_CNT increments.
- Reads are processed in order; there is no back-pressure on readdatavalid.
- Reset mid-operation: in-flight reads are flushed and no readdatavalid is issued for them. Registers and counters reset; RAM contents are retained but undefined.

## Timing
- Reset values: waitrequest=1, readdatavalid=0, readdata=0.
- Read latency: a read accepted at edge T produces readdatavalid=1 during the cycle after edge T+READ_LATENCY-1, i.e. exactly READ_LATENCY cycles after acceptance.
- Read throughput: one read per cycle; up to READ_LATENCY reads in flight.
- Readdata holds its last value when readdatavalid=0.
- Read-after-write: a read accepted one cycle after a write to the same address returns the new data (RAM is write-first, or forwarded).
- Freeze: asserting freeze raises waitrequest in the same cycle.
  - Reads already accepted still complete on schedule.
  - Deasserting freeze allows acceptance at the next edge.
- Counter reads return the value before the edge at which the read is accepted.

## Structure
- Package s6_avmm_pkg holds:
  - address constants (ID, SCRATCH, WR_CNT, RD_CNT, ERR_CNT, RAM_BASE, RAM_WORDS);
  - UNMAPPED_DATA (32'hDEAD_BEEF);
  - a region-decode enum typedef.
- Sub-module s6_resp_ram: 256x32 single-port RAM with byte-enable, registered read output and write-first behaviour.
  - The remaining READ_LATENCY-1 stages are a valid/data shift pipeline in the top module.
  - Register and counter read data are muxed into stage 1 of that pipeline.

## Test plan
- Reset release: read 0x00000 → readdatavalid exactly 2 cycles after accept with 32'h5336_0001; waitrequest=1 until the first edge after rst goes high.
- Byte-enable write: write 0x01010 = 32'hAABBCCDD with byteenable 4'b0101, then read back → 32'h00BB00DD, assuming the word was previously written to 0.
- Back-to-back traffic: 8 consecutive RAM reads, one per cycle → 8 in-order readdatavalid pulses on consecutive cycles; RD_CNT=8.
- Error paths:
  - unmapped read 0x40000 → 32'hDEAD_BEEF and ERR_CNT=1;
  - simultaneous read+write → write applied, no readdatavalid, ERR_CNT=2.
- Freeze: freeze asserted with 2 reads in flight → both complete; waitrequest=1 and no new acceptance while freeze=1.
- Counter wrap and reset flush:
  - WR_CNT wraps to 0 after 0xFFFF_FFFF (preload via force);
  - rst asserted with reads in flight → no readdatavalid afterwards.
